// File: rtl/mssd_frame_sequencer_if.sv
// Handshake bundle for mssd_frame_sequencer: serial input, byte output stream and status pulses.
// master = the sequencer, slave = the serial source / byte consumer.
interface mssd_frame_sequencer_if;
    logic       si;
    logic       out_ready;
    logic [7:0] out_data;
    logic [1:0] out_port;
    logic       out_valid;
    logic       frame_done;
    logic       error;
    logic       busy;

    modport master (
        input  si, out_ready,
        output out_data, out_port, out_valid, frame_done, error, busy
    );

    modport slave (
        output si, out_ready,
        input  out_data, out_port, out_valid, frame_done, error, busy
    );
endinterface

// File: rtl/mssd_frame_sequencer.sv
// Serial frame sequencer: start bit, 2-bit port, 4-bit count N, then N MSB-first bytes.
// Define MSSD_PARITY_EN to add an even-parity bit after every data byte.
module mssd_frame_sequencer (
    input logic                    clk,
    input logic                    rst,
    mssd_frame_sequencer_if.master bus
);
    typedef enum logic [1:0] {IDLE, HDR, DATA, DRAIN} state_t;

`ifdef MSSD_PARITY_EN
    localparam logic [3:0] BIT_LAST = 4'd8;
    logic [7:0] shift;
    logic       parity_ok;
`else
    localparam logic [3:0] BIT_LAST = 4'd7;
    logic [6:0] shift;
`endif

    state_t     state;
    logic [3:0] bit_cnt;
    logic [3:0] byte_cnt;
    logic [1:0] port_q;
    logic [5:0] hdr_word;
    logic [7:0] data_byte;
    logic       stall;

    always_comb begin
        hdr_word = {shift[4:0], bus.si};
`ifdef MSSD_PARITY_EN
        data_byte = shift;
        parity_ok = ~(^{shift, bus.si});
`else
        data_byte = {shift, bus.si};
`endif
        stall = bus.out_valid & ~bus.out_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            bit_cnt        <= '0;
            byte_cnt       <= '0;
            shift          <= '0;
            port_q         <= '0;
            bus.out_data   <= '0;
            bus.out_port   <= '0;
            bus.out_valid  <= 1'b0;
            bus.frame_done <= 1'b0;
            bus.error      <= 1'b0;
            bus.busy       <= 1'b0;
        end else begin
            bus.frame_done <= 1'b0;
            bus.error      <= 1'b0;
            if (bus.out_valid && bus.out_ready)
                bus.out_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (!bus.si) begin
                        state    <= HDR;
                        bus.busy <= 1'b1;
                        bit_cnt  <= '0;
                    end
                end

                HDR: begin
                    shift <= {shift[$bits(shift)-2:0], bus.si};
                    if (bit_cnt == 4'd5) begin
                        port_q   <= hdr_word[5:4];
                        byte_cnt <= hdr_word[3:0];
                        bit_cnt  <= '0;
                        if (hdr_word[3:0] == 4'd0) begin
                            state          <= IDLE;
                            bus.busy       <= 1'b0;
                            bus.frame_done <= 1'b1;
                        end else begin
                            state <= DATA;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                end

                DATA: begin
                    if (bit_cnt != BIT_LAST) begin
                        shift   <= {shift[$bits(shift)-2:0], bus.si};
                        bit_cnt <= bit_cnt + 4'd1;
                    end else begin
                        bit_cnt <= '0;
                        // A bad-parity byte is dropped before the overflow check can see it.
`ifdef MSSD_PARITY_EN
                        if (!parity_ok) begin
                            bus.error <= 1'b1;
                            byte_cnt  <= byte_cnt - 4'd1;
                            if (byte_cnt == 4'd1)
                                state <= DRAIN;
                        end else
`endif
                        if (stall) begin
                            bus.error     <= 1'b1;
                            bus.out_valid <= 1'b0;
                            bus.busy      <= 1'b0;
                            byte_cnt      <= '0;
                            state         <= IDLE;
                        end else begin
                            bus.out_data  <= data_byte;
                            bus.out_port  <= port_q;
                            bus.out_valid <= 1'b1;
                            byte_cnt      <= byte_cnt - 4'd1;
                            if (byte_cnt == 4'd1)
                                state <= DRAIN;
                        end
                    end
                end

                DRAIN: begin
                    // Also covers a dropped final byte, where nothing is pending.
                    if (!bus.out_valid || bus.out_ready) begin
                        bus.out_valid  <= 1'b0;
                        bus.frame_done <= 1'b1;
                        bus.busy       <= 1'b0;
                        state          <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mssd_frame_sequencer.sv
// Self-checking bench for mssd_frame_sequencer (default build, no parity): timeline model plus literal pins.
module tb_mssd_frame_sequencer;
    localparam int MAXC = 80;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mssd_frame_sequencer_if bus();
    mssd_frame_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

    // index c = value sampled at / produced by rising edge c of the current segment
    logic       si_arr    [MAXC];
    logic       rdy_arr   [MAXC];
    logic       exp_valid [MAXC];
    logic       exp_done  [MAXC];
    logic       exp_err   [MAXC];
    logic       exp_busy  [MAXC];
    logic [7:0] exp_data  [MAXC];
    logic [1:0] exp_port  [MAXC];
    logic [7:0] byt       [16];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    logic chk_en = 1'b0;

    int first_valid, nvalid, done_cyc, err_cyc;
    logic [7:0] first_data;
    logic [1:0] first_port;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic chk_outputs_zero(input string name);
        chk({name, "_valid"}, {31'd0, bus.out_valid}, 0);
        chk({name, "_done"},  {31'd0, bus.frame_done}, 0);
        chk({name, "_err"},   {31'd0, bus.error}, 0);
        chk({name, "_busy"},  {31'd0, bus.busy}, 0);
        chk({name, "_data"},  {24'd0, bus.out_data}, 0);
        chk({name, "_port"},  {30'd0, bus.out_port}, 0);
    endtask

    // Single per-cycle compare against the model timeline
    always @(negedge clk) begin
        if (chk_en) begin
            chk("valid", {31'd0, bus.out_valid},  {31'd0, exp_valid[cyc]});
            chk("done",  {31'd0, bus.frame_done}, {31'd0, exp_done[cyc]});
            chk("error", {31'd0, bus.error},      {31'd0, exp_err[cyc]});
            chk("busy",  {31'd0, bus.busy},       {31'd0, exp_busy[cyc]});
            if (exp_valid[cyc]) begin
                chk("data", {24'd0, bus.out_data}, {24'd0, exp_data[cyc]});
                chk("port", {30'd0, bus.out_port}, {30'd0, exp_port[cyc]});
            end
            if (bus.out_valid) begin
                if (first_valid < 0) begin
                    first_valid = cyc;
                    first_data  = bus.out_data;
                    first_port  = bus.out_port;
                end
                if (bus.out_ready) nvalid++;
            end
            if (bus.frame_done) done_cyc = cyc;
            if (bus.error) err_cyc = cyc;
        end
    end

    task automatic seg_init();
        rst = 1'b1;
        for (int c = 0; c < MAXC; c++) begin
            si_arr[c] = 1'b1; rdy_arr[c] = 1'b0;
            exp_valid[c] = 1'b0; exp_done[c] = 1'b0; exp_err[c] = 1'b0; exp_busy[c] = 1'b0;
            exp_data[c] = 8'h00; exp_port[c] = 2'b00;
        end
        first_valid = -1; nvalid = 0; done_cyc = -1; err_cyc = -1;
        first_data = 8'h00; first_port = 2'b00;
        repeat (2) @(posedge clk);
        #1 chk_outputs_zero("reset");
    endtask

    task automatic put_frame(input int s, input logic [1:0] p, input int n);
        logic [5:0] hdr;
        logic [7:0] b;
        hdr = {p, n[3:0]};
        si_arr[s] = 1'b0;
        for (int i = 0; i < 6; i++) si_arr[s + 1 + i] = hdr[5 - i];
        for (int k = 0; k < n; k++) begin
            b = byt[k];
            for (int i = 0; i < 8; i++) si_arr[s + 7 + 8 * k + i] = b[7 - i];
        end
    endtask

    // Timeline model: byte k completes at s+14+8k; it transfers at the first later edge with
    // ready; no ready edge up to the next completion means overflow there.
    task automatic model_frame(input int s, input logic [1:0] p, input int n, output int fin);
        int e, t;
        fin = s + 6;
        if (n == 0) begin
            exp_done[s + 6] = 1'b1;
        end else begin
            for (int k = 0; k < n; k++) begin
                e = s + 14 + 8 * k;
                t = e + 1;
                while (t < MAXC && !rdy_arr[t]) t++;
                if (k < n - 1 && t > e + 8) begin
                    for (int c = e; c < e + 8; c++) begin
                        exp_valid[c] = 1'b1; exp_data[c] = byt[k]; exp_port[c] = p;
                    end
                    exp_err[e + 8] = 1'b1;
                    fin = e + 8;
                    break;
                end
                for (int c = e; c < t && c < MAXC; c++) begin
                    exp_valid[c] = 1'b1; exp_data[c] = byt[k]; exp_port[c] = p;
                end
                if (k == n - 1) begin
                    if (t < MAXC) exp_done[t] = 1'b1;
                    fin = t;
                end
            end
        end
        for (int c = s; c < fin && c < MAXC; c++) exp_busy[c] = 1'b1;
    endtask

    task automatic run_seg(input int ncyc);
        @(negedge clk);
        bus.si = si_arr[0];
        bus.out_ready = rdy_arr[0];
        rst = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk);
            #1;
            cyc = c;
            chk_en = 1'b1;
            if (c + 1 < MAXC) begin
                bus.si = si_arr[c + 1];
                bus.out_ready = rdy_arr[c + 1];
            end
        end
        @(negedge clk);
        #1 chk_en = 1'b0;
    endtask

    initial begin
        int fin;
        bus.si = 1'b1;
        bus.out_ready = 1'b0;

        // Port 10, two bytes, always ready
        seg_init();
        byt[0] = 8'hA5; byt[1] = 8'h3C;
        for (int c = 0; c < MAXC; c++) rdy_arr[c] = 1'b1;
        put_frame(2, 2'b10, 2);
        model_frame(2, 2'b10, 2, fin);
        run_seg(32);
        chk("A_first_valid", first_valid, 16);
        chk("A_first_data", {24'd0, first_data}, 32'hA5);
        chk("A_port", {30'd0, first_port}, 2);
        chk("A_transfers", nvalid, 2);
        chk("A_done_cyc", done_cyc, 25);

        // Port 01, empty frame
        seg_init();
        put_frame(1, 2'b01, 0);
        model_frame(1, 2'b01, 0, fin);
        run_seg(12);
        chk("B_done_cyc", done_cyc, 7);
        chk("B_no_valid", first_valid, -1);

        // Two bytes, never ready: overflow on the second
        seg_init();
        byt[0] = 8'h12; byt[1] = 8'h34;
        put_frame(0, 2'b11, 2);
        model_frame(0, 2'b11, 2, fin);
        run_seg(28);
        chk("C_err_cyc", err_cyc, 22);
        chk("C_held_data", {24'd0, first_data}, 32'h12);
        chk("C_no_done", done_cyc, -1);

        // One byte, ready delayed five cycles
        seg_init();
        byt[0] = 8'h5A;
        for (int c = 20; c < MAXC; c++) rdy_arr[c] = 1'b1;
        put_frame(0, 2'b00, 1);
        model_frame(0, 2'b00, 1, fin);
        run_seg(26);
        chk("D_done_cyc", done_cyc, 20);

        // Same-edge accept/load, start bits ignored in DRAIN, back-to-back frame
        seg_init();
        byt[0] = 8'h11; byt[1] = 8'h22; byt[2] = 8'h33;
        rdy_arr[23] = 1'b1; rdy_arr[31] = 1'b1;
        for (int c = 35; c < MAXC; c++) rdy_arr[c] = 1'b1;
        put_frame(1, 2'b00, 3);
        model_frame(1, 2'b00, 3, fin);
        chk("E_model_fin", fin, 35);
        for (int c = 32; c < 36; c++) si_arr[c] = 1'b0;
        byt[0] = 8'h81;
        put_frame(36, 2'b10, 1);
        model_frame(36, 2'b10, 1, fin);
        run_seg(56);
        chk("E_no_err", err_cyc, -1);
        chk("E_transfers", nvalid, 4);
        chk("E_done_cyc", done_cyc, 51);

        // Reset mid-byte, then a clean frame
        seg_init();
        byt[0] = 8'hC3; byt[1] = 8'h96;
        for (int c = 0; c < MAXC; c++) rdy_arr[c] = 1'b1;
        put_frame(0, 2'b01, 2);
        model_frame(0, 2'b01, 2, fin);
        run_seg(11);
        rst = 1'b1;
        #1 chk_outputs_zero("midrst");
        seg_init();
        byt[0] = 8'hFF;
        for (int c = 0; c < MAXC; c++) rdy_arr[c] = 1'b1;
        put_frame(0, 2'b11, 1);
        model_frame(0, 2'b11, 1, fin);
        run_seg(20);
        chk("F_data", {24'd0, first_data}, 32'hFF);
        chk("F_port", {30'd0, first_port}, 3);
        chk("F_done_cyc", done_cyc, 15);
        chk("F_no_err", err_cyc, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
